// File: rtl/button_event.sv
// Turns a debounced button level into press/release/long_press/repeat pulses.
// Optional auto-repeat is enabled by defining AUTO_REPEAT_EN.
module button_event #(
    parameter int CLK_FREQ      = 50_000_000,
    parameter int LONG_PRESS_MS = 1000,
    parameter int REPEAT_MS     = 200
) (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic press,
    output logic release_p,
    output logic long_press,
    output logic repeat_p,
    output logic held
);

    localparam logic [31:0] LONG_CNT = 32'(CLK_FREQ / 1000 * LONG_PRESS_MS);
`ifdef AUTO_REPEAT_EN
    localparam logic [31:0] REP_CNT  = 32'(CLK_FREQ / 1000 * REPEAT_MS);
`endif

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESSED   = 2'd1,
        LONG_HELD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] count_q, count_d;
    logic        level_q;
    logic        press_q, press_d;
    logic        release_q, release_d;
    logic        long_q, long_d;
`ifdef AUTO_REPEAT_EN
    logic        repeat_q, repeat_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            count_q   <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
`ifdef AUTO_REPEAT_EN
            repeat_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            level_q   <= level;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
`ifdef AUTO_REPEAT_EN
            repeat_q  <= repeat_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
`ifdef AUTO_REPEAT_EN
        repeat_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (level && !level_q) begin
                    press_d = 1'b1;
                    count_d = '0;
                    state_d = PRESSED;
                end
            end
            PRESSED: begin
                // Release is checked first so it wins over a coincident terminal count.
                if (!level) begin
                    release_d = 1'b1;
                    count_d   = '0;
                    state_d   = IDLE;
                end else if (count_q == LONG_CNT - 32'd1) begin
                    long_d  = 1'b1;
                    count_d = '0;
                    state_d = LONG_HELD;
                end else begin
                    count_d = count_q + 32'd1;
                end
            end
            LONG_HELD: begin
                if (!level) begin
                    release_d = 1'b1;
                    count_d   = '0;
                    state_d   = IDLE;
                end else begin
`ifdef AUTO_REPEAT_EN
                    if (count_q == REP_CNT - 32'd1) begin
                        repeat_d = 1'b1;
                        count_d  = '0;
                    end else begin
                        count_d = count_q + 32'd1;
                    end
`else
                    count_d = '0;
`endif
                end
            end
            default: begin
                count_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign press      = press_q;
    assign release_p  = release_q;
    assign long_press = long_q;
    assign held       = level_q;
`ifdef AUTO_REPEAT_EN
    assign repeat_p   = repeat_q;
`else
    assign repeat_p   = 1'b0;
`endif

endmodule

// File: tb/tb_button_event.sv
// Randomized bench for button_event with a hold-length reference model
// plus directed scenarios pinned to literal edge offsets.
module tb_button_event;

    localparam int LONG = 10;
    localparam int REP  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic level = 1'b0;
    logic press, release_p, long_press, repeat_p, held;

    int checks = 0;
    int errors = 0;

    // Reference model: edge-level view of how long the button has been held.
    logic m_prev;
    int   m_hold;
    logic e_press, e_release, e_long, e_rep, e_held;

    button_event #(
        .CLK_FREQ      (1000),
        .LONG_PRESS_MS (LONG),
        .REPEAT_MS     (REP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .level      (level),
        .press      (press),
        .release_p  (release_p),
        .long_press (long_press),
        .repeat_p   (repeat_p),
        .held       (held)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_prev = 1'b0; m_hold = 0;
            e_press = 0; e_release = 0; e_long = 0; e_rep = 0; e_held = 0;
        end else begin
            e_press = 0; e_release = 0; e_long = 0; e_rep = 0;
            if (level && !m_prev) begin
                e_press = 1;
                m_hold  = 0;
            end else if (level && m_prev) begin
                m_hold++;
                if (m_hold == LONG) e_long = 1;
`ifdef AUTO_REPEAT_EN
                else if (m_hold > LONG && (m_hold - LONG) % REP == 0) e_rep = 1;
`endif
            end else if (!level && m_prev) begin
                e_release = 1;
            end
            m_prev = level;
            e_held = level;
        end
    end

    always @(negedge clk) begin
        check("press",      int'(press),      int'(e_press));
        check("release_p",  int'(release_p),  int'(e_release));
        check("long_press", int'(long_press), int'(e_long));
        check("repeat_p",   int'(repeat_p),   int'(e_rep));
        check("held",       int'(held),       int'(e_held));
    end

    // Drive level for n edges then sample DUT pulses; returns offsets from the first edge.
    int p_at, l_at, rel_at, r_cnt, r_last, p_cnt, rel_cnt;

    task automatic clear_log();
        p_at = -1; l_at = -1; rel_at = -1; r_cnt = 0; r_last = -1; p_cnt = 0; rel_cnt = 0;
    endtask

    task automatic log_edge(input int i);
        @(posedge clk);
        #1;
        if (press)      begin p_at = i; p_cnt++; end
        if (long_press) l_at = i;
        if (release_p)  begin rel_at = i; rel_cnt++; end
        if (repeat_p)   begin r_cnt++; r_last = i; end
    endtask

    // level=1 sampled at edges 0..n-1, level=0 at edge n; logs edges 0..n+1.
    task automatic hold_for(input int n);
        clear_log();
        @(negedge clk); level = 1'b1;
        for (int i = 0; i <= n + 1; i++) begin
            if (i == n) level = 1'b0;
            log_edge(i);
            @(negedge clk);
            if (i + 1 == n) level = 1'b0;
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk); level = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [6:0] pat;
        int run;
        // 1: reset state, then quiet with level=0
        #2;
        check("reset_press", int'(press), 0);
        check("reset_held",  int'(held),  0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_log();
        for (int i = 0; i < 20; i++) log_edge(i);
        check("quiet_pulses", p_cnt + rel_cnt + r_cnt + (l_at >= 0 ? 1 : 0), 0);

        // 2: short hold of 5
        hold_for(5);
        check("short_press_at", p_at, 0);
        check("short_release_at", rel_at, 5);
        check("short_no_long", l_at, -1);
        idle(3);

        // 3: hold of 25
        hold_for(25);
        check("hold_press_at", p_at, 0);
        check("hold_long_at", l_at, 10);
        check("hold_release_at", rel_at, 25);
`ifdef AUTO_REPEAT_EN
        check("hold_rep_cnt", r_cnt, 3);
        check("hold_rep_last", r_last, 22);
`else
        check("hold_rep_cnt", r_cnt, 0);
`endif
        idle(3);

        // 4: release coincides with terminal count
        hold_for(10);
        check("coinc_release_at", rel_at, 10);
        check("coinc_no_long", l_at, -1);
        idle(3);

        // 5: reset mid-hold with level kept high
        clear_log();
        @(negedge clk); level = 1'b1;
        for (int i = 0; i < 6; i++) log_edge(i);
        #1 rst = 1'b1;
        #1;
        check("rst_held_drop", int'(held), 0);
        check("rst_press_drop", int'(press), 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        clear_log();
        for (int i = 0; i < 12; i++) log_edge(i);
        check("rst_press_at", p_at, 0);
        check("rst_long_at", l_at, 10);
        check("rst_no_release", rel_cnt, 0);
        idle(3);

        // 6: pattern 1,1,1,0,1,1,0
        pat = 7'b0110111;
        clear_log();
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            level = (i < 7) ? pat[i] : 1'b0;
            log_edge(i);
        end
        check("pat_press_cnt", p_cnt, 2);
        check("pat_release_cnt", rel_cnt, 2);
        check("pat_last_press", p_at, 4);
        check("pat_last_release", rel_at, 6);
        idle(3);

        // Randomized runs of varying length, occasional async reset
        for (int r = 0; r < 150; r++) begin
            run = ($urandom_range(0, 3) == 0) ? int'($urandom_range(8, 30)) : int'($urandom_range(1, 6));
            @(negedge clk);
            level = ~level;
            repeat (run - 1) @(negedge clk);
            if ($urandom_range(0, 19) == 0) begin
                #1 rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        end
        idle(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
